// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART receive-side byte buffer.
//   UART_DATA_W     : received byte width
//   FIFO_ENTRY_W    : stored entry width (parity-error flag + data byte)
//   FIFO_DEPTH_DEF  : default FIFO depth
//   CTS_HI_WM_DEF   : default high watermark (CTS asserts at or above)
//   CTS_LO_WM_DEF   : default low watermark (CTS deasserts at or below)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int FIFO_ENTRY_W   = UART_DATA_W + 1;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int CTS_HI_WM_DEF  = 12;
    localparam int CTS_LO_WM_DEF  = 4;

    // One stored frame: parity-error flag sits in the MSB above the data byte.
    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } fifo_entry_t;

    // Per-cycle FIFO operation, encoded as {write, read}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    // Build a storage entry from a received frame.
    function automatic fifo_entry_t pack_entry(input logic perr,
                                               input logic [UART_DATA_W-1:0] data);
        fifo_entry_t e;
        e.perr = perr;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x FIFO_ENTRY_W register array for the receive FIFO. Storage is not
// reset; the top level masks the head output while the FIFO is empty.
// Ports:
//   iClk     : clock
//   wr_en    : write enable (synchronous write port)
//   wr_addr  : write address
//   wr_data  : entry to store
//   rd_addr  : read address (asynchronous read port)
//   rd_data  : entry at rd_addr, combinational
// -----------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          iClk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  fifo_entry_t   wr_data,
    input  logic [AW-1:0] rd_addr,
    output fifo_entry_t   rd_data
);

    fifo_entry_t mem_r [DEPTH];

    // Synchronous write of one entry.
    always_ff @(posedge iClk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Show-ahead read: head entry visible without a clock.
    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer between the UART receiver and the keycode consumer.
// Captures a frame on the rising edge of the receiver's valid level, stores
// {parity error, data} in a show-ahead FIFO and drives the receiver's CTS
// hold input from registered high/low watermarks with hysteresis.
//
// Optional feature macro: UART_RX_FIFO_DROP_PERR_EN
//   defined   : frames with a parity error are discarded, oPerr_drop pulses
//               for one cycle per discarded frame, oRd_perr is tied to 0.
//   undefined : every frame is stored and oRd_perr reports its flag.
//
// Ports:
//   iClk, iRst   : clock, asynchronous active-high reset
//   iData_rx     : received byte
//   iData_valid  : receiver valid level (held until the next frame)
//   iPar_err     : receiver parity-error flag, valid with iData_valid
//   oCTS         : 1 = hold the receiver
//   iRd_en       : pop head entry (ignored when empty)
//   oRd_data     : head byte, 0 while empty
//   oRd_perr     : head entry parity-error flag
//   oEmpty/oFull : occupancy flags
//   oCount       : occupancy 0..DEPTH
//   oOverflow    : sticky frame-dropped-while-full flag
//   iClr_ovf     : clears oOverflow
//   oPerr_drop   : (macro only) one-cycle pulse per discarded parity frame
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int HI_WM = CTS_HI_WM_DEF,
    parameter int LO_WM = CTS_LO_WM_DEF
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic [UART_DATA_W-1:0]   iData_rx,
    input  logic                     iData_valid,
    input  logic                     iPar_err,
    output logic                     oCTS,
    input  logic                     iRd_en,
    output logic [UART_DATA_W-1:0]   oRd_data,
    output logic                     oRd_perr,
    output logic                     oEmpty,
    output logic                     oFull,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oOverflow,
`ifdef UART_RX_FIFO_DROP_PERR_EN
    input  logic                     iClr_ovf,
    output logic                     oPerr_drop
`else
    input  logic                     iClr_ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] HI_C    = CW'(HI_WM);
    localparam logic [CW-1:0] LO_C    = CW'(LO_WM);

    logic          valid_d_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          empty_r;
    logic          full_r;
    logic          cts_r;
    logic          ovf_r;

    logic          wr_strobe_s;
    logic          wr_req_s;
    logic          wr_do_s;
    logic          rd_do_s;
    logic          drop_s;
    fifo_op_e      op_s;
    logic [CW-1:0] count_next_s;
    logic          cts_next_s;
    logic          ovf_next_s;
    fifo_entry_t   head_s;

    // A new frame is the rising edge of the receiver's valid level.
    assign wr_strobe_s = iData_valid & ~valid_d_r;

`ifdef UART_RX_FIFO_DROP_PERR_EN
    logic perr_drop_r;

    // Parity-errored frames never reach the FIFO.
    assign wr_req_s = wr_strobe_s & ~iPar_err;

    // One-cycle pulse for each discarded parity frame.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            perr_drop_r <= 1'b0;
        end else begin
            perr_drop_r <= wr_strobe_s & iPar_err;
        end
    end

    assign oPerr_drop = perr_drop_r;
`else
    assign wr_req_s = wr_strobe_s;
`endif

    // A read when full frees the slot the same-edge write lands in.
    assign rd_do_s = iRd_en & ~empty_r;
    assign wr_do_s = wr_req_s & (~full_r | rd_do_s);
    assign drop_s  = wr_req_s & full_r & ~rd_do_s;
    assign op_s    = fifo_op_e'({wr_do_s, rd_do_s});

    // Next occupancy from the accepted operations.
    always_comb begin
        count_next_s = count_r;
        case (op_s)
            OP_WR:    count_next_s = count_r + CW'(1);
            OP_RD:    count_next_s = count_r - CW'(1);
            OP_WR_RD: count_next_s = count_r;
            OP_IDLE:  count_next_s = count_r;
            default:  count_next_s = count_r;
        endcase
    end

    // CTS hysteresis evaluated on the next occupancy so it lands with the count.
    always_comb begin
        cts_next_s = cts_r;
        if (count_next_s >= HI_C) begin
            cts_next_s = 1'b1;
        end else if (count_next_s <= LO_C) begin
            cts_next_s = 1'b0;
        end else begin
            cts_next_s = cts_r;
        end
    end

    // Sticky overflow: a drop wins over a same-cycle clear.
    always_comb begin
        ovf_next_s = ovf_r;
        if (drop_s) begin
            ovf_next_s = 1'b1;
        end else if (iClr_ovf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Edge-detector history; resets high so a valid level held through reset is not a frame.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            valid_d_r <= 1'b1;
        end else begin
            valid_d_r <= iData_valid;
        end
    end

    // Pointers with natural wrap.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (wr_do_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_do_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy, flags, CTS and overflow registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            count_r <= {CW{1'b0}};
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            cts_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            empty_r <= (count_next_s == {CW{1'b0}});
            full_r  <= (count_next_s == DEPTH_C);
            cts_r   <= cts_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .iClk    (iClk),
        .wr_en   (wr_do_s),
        .wr_addr (wr_ptr_r),
        .wr_data (pack_entry(iPar_err, iData_rx)),
        .rd_addr (rd_ptr_r),
        .rd_data (head_s)
    );

    // Head is masked while empty so outputs are defined straight out of reset.
    assign oRd_data = empty_r ? {UART_DATA_W{1'b0}} : head_s.data;
`ifdef UART_RX_FIFO_DROP_PERR_EN
    assign oRd_perr = 1'b0;
`else
    assign oRd_perr = empty_r ? 1'b0 : head_s.perr;
`endif

    assign oCTS      = cts_r;
    assign oEmpty    = empty_r;
    assign oFull     = full_r;
    assign oCount    = count_r;
    assign oOverflow = ovf_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] data_rx;
    logic       data_valid;
    logic       par_err;
    logic       cts;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       ovf;
    logic       clr_ovf;
`ifdef UART_RX_FIFO_DROP_PERR_EN
    logic       perr_drop;
`endif

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DEPTH(16), .HI_WM(12), .LO_WM(4)) dut (
        .iClk        (clk),
        .iRst        (rst),
        .iData_rx    (data_rx),
        .iData_valid (data_valid),
        .iPar_err    (par_err),
        .oCTS        (cts),
        .iRd_en      (rd_en),
        .oRd_data    (rd_data),
        .oRd_perr    (rd_perr),
        .oEmpty      (empty),
        .oFull       (full),
        .oCount      (count),
        .oOverflow   (ovf),
`ifdef UART_RX_FIFO_DROP_PERR_EN
        .iClr_ovf    (clr_ovf),
        .oPerr_drop  (perr_drop)
`else
        .iClr_ovf    (clr_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: valid high for one edge (write), then low for one edge.
    task automatic send_frame(input logic [7:0] d, input logic pe);
        data_rx    = d;
        par_err    = pe;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        par_err    = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_valid = 1'b1; data_rx = 8'h99; par_err = 1'b0;
        rd_en = 1'b0; clr_ovf = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0 || cts !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_flags got full=%b cts=%b ovf=%b exp=000", full, cts, ovf); end
        total++; if (rd_data !== 8'h00 || rd_perr !== 1'b0) begin bad++; $display("FAIL reset_head got=%h/%b exp=00/0", rd_data, rd_perr); end
        data_valid = 1'b0;
        tick();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_valid_fall got=%0d exp=0", count); end
    endtask

    task automatic test_order();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h1C; exp_q[1] = 8'h32; exp_q[2] = 8'h21;
        for (int i = 0; i < 3; i++) send_frame(exp_q[i], 1'b0);
        total++; if (count !== 5'd3) begin bad++; $display("FAIL order_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rd_data !== exp_q[i]) begin bad++; $display("FAIL order_head%0d got=%h exp=%h", i, rd_data, exp_q[i]); end
            pop();
        end
        total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL order_empty got empty=%b count=%0d exp=1/0", empty, count); end
    endtask

    task automatic test_watermark();
        for (int i = 0; i < 11; i++) send_frame(8'(i), 1'b0);
        total++; if (cts !== 1'b0) begin bad++; $display("FAIL wm_cts11 got=%b exp=0", cts); end
        data_rx = 8'd11; data_valid = 1'b1;
        tick();
        total++; if (cts !== 1'b1 || count !== 5'd12) begin bad++; $display("FAIL wm_cts12 got cts=%b count=%0d exp=1/12", cts, count); end
        data_valid = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) pop();
        total++; if (cts !== 1'b1 || count !== 5'd5) begin bad++; $display("FAIL wm_cts5 got cts=%b count=%0d exp=1/5", cts, count); end
        pop();
        total++; if (cts !== 1'b0 || count !== 5'd4) begin bad++; $display("FAIL wm_cts4 got cts=%b count=%0d exp=0/4", cts, count); end
        for (int i = 0; i < 4; i++) pop();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wm_drain got=%b exp=1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0);
        total++; if (full !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_full got full=%b count=%0d exp=1/16", full, count); end
        send_frame(8'hAA, 1'b0);
        total++; if (ovf !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_drop got ovf=%b count=%0d exp=1/16", ovf, count); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL ovf_head got=%h exp=00", rd_data); end
        data_rx = 8'h77; data_valid = 1'b1; rd_en = 1'b1;
        tick();
        data_valid = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd16 || full !== 1'b1 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_wrrd_full got count=%0d full=%b ovf=%b exp=16/1/1", count, full, ovf); end
        tick();
        // Clear while a drop happens in the same cycle: set must win.
        data_rx = 8'hBB; data_valid = 1'b1; clr_ovf = 1'b1;
        tick();
        data_valid = 1'b0;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_prio got=%b exp=1", ovf); end
        tick();
        clr_ovf = 1'b0;
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        for (int i = 1; i < 16; i++) begin
            total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL ovf_order%0d got=%h exp=%h", i, rd_data, 8'(i)); end
            pop();
        end
        total++; if (rd_data !== 8'h77 || count !== 5'd1) begin bad++; $display("FAIL ovf_tail got=%h count=%0d exp=77/1", rd_data, count); end
        pop();
        total++; if (empty !== 1'b1 || cts !== 1'b0) begin bad++; $display("FAIL ovf_drain got empty=%b cts=%b exp=1/0", empty, cts); end
    endtask

    task automatic test_empty_wrrd();
        data_rx = 8'h3C; data_valid = 1'b1; rd_en = 1'b1;
        tick();
        data_valid = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd1 || rd_data !== 8'h3C) begin bad++; $display("FAIL empty_wrrd got count=%0d head=%h exp=1/3C", count, rd_data); end
        tick();
        pop();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_wrrd_pop got=%b exp=1", empty); end
    endtask

    task automatic test_parity();
        data_rx = 8'h55; par_err = 1'b1; data_valid = 1'b1;
        tick();
        data_valid = 1'b0; par_err = 1'b0;
`ifdef UART_RX_FIFO_DROP_PERR_EN
        total++; if (perr_drop !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL perr_drop got pulse=%b count=%0d exp=1/0", perr_drop, count); end
        tick();
        total++; if (perr_drop !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL perr_drop_end got pulse=%b empty=%b exp=0/1", perr_drop, empty); end
`else
        total++; if (rd_data !== 8'h55 || rd_perr !== 1'b1 || count !== 5'd1) begin bad++; $display("FAIL perr_store got=%h/%b count=%0d exp=55/1/1", rd_data, rd_perr, count); end
        tick();
        send_frame(8'h66, 1'b0);
        pop();
        total++; if (rd_data !== 8'h66 || rd_perr !== 1'b0) begin bad++; $display("FAIL perr_clean got=%h/%b exp=66/0", rd_data, rd_perr); end
        pop();
`endif
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) send_frame(8'(8'h40 + i), 1'b0);
        total++; if (count !== 5'd7) begin bad++; $display("FAIL arst_fill got=%0d exp=7", count); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (count !== 5'd0 || empty !== 1'b1 || cts !== 1'b0) begin bad++; $display("FAIL arst_async got count=%0d empty=%b cts=%b exp=0/1/0", count, empty, cts); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (empty !== 1'b1 || rd_data !== 8'h00) begin bad++; $display("FAIL arst_after got empty=%b head=%h exp=1/00", empty, rd_data); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_watermark();
        test_overflow();
        test_empty_wrrd();
        test_parity();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
